// File: rtl/dhtk_pkg.sv
// dhtk_pkg: shared definitions for the century-clock timestamp transmitter.
//   - calendar field widths as produced by main_control
//   - default packet sync byte
//   - packet length in bytes (grows by one when DHTK_TX_CHECKSUM_EN is defined)
//   - packet-level transmit state enum
package dhtk_pkg;

   localparam int SEC_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HOUR_W  = 5;
   localparam int DAY_W   = 5;
   localparam int MONTH_W = 4;
   localparam int YEAR_W  = 12;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef DHTK_TX_CHECKSUM_EN
   localparam int NUM_BYTES = 8;
`else
   localparam int NUM_BYTES = 7;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4
   } tx_state_t;

endpackage

// File: rtl/dhtk_uart_byte_tx.sv
// dhtk_uart_byte_tx: 8N1 serializer for one byte.
//   clk, rst_p  : clock, synchronous active-high reset
//   load        : start a new frame with byte_in (start bit appears after this edge);
//                 may coincide with byte_done to chain frames with no gap
//   byte_in     : byte to send, LSB first
//   txd         : serial line, idle high
//   start_end   : last cycle of the start bit
//   data_end    : last cycle of data bit 7
//   byte_done   : last cycle of the stop bit
module dhtk_uart_byte_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst_p,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       txd,
   output logic       start_end,
   output logic       data_end,
   output logic       byte_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]    shreg;
   logic          active;
   logic          bit_end;

   assign bit_end   = active && (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign start_end = bit_end && (bit_cnt == 4'd0);
   assign data_end  = bit_end && (bit_cnt == 4'd8);
   assign byte_done = bit_end && (bit_cnt == 4'd9);

   always_ff @(posedge clk) begin
      if (rst_p) begin
         txd      <= 1'b1;
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (load) begin
         txd      <= 1'b0;
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= byte_in;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            // the line always carries the bit that follows the one ending now
            if (bit_cnt < 4'd8) begin
               txd   <= shreg[0];
               shreg <= {1'b0, shreg[7:1]};
            end else begin
               txd <= 1'b1;
            end
            if (bit_cnt == 4'd9)
               active <= 1'b0;
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dhtk_time_tx.sv
// dhtk_time_tx: serial timestamp transmitter for the century clock.
// Snapshots sec/min/hour/day/month/year on a second change or send_req and
// sends SYNC, sec, min, hour, day, {month,year[11:8]}, year[7:0] as
// back-to-back 8N1 frames. With DHTK_TX_CHECKSUM_EN defined an eighth byte,
// the XOR of bytes 1..6, is appended.
//   clk, rst_p   : clock, synchronous active-high reset
//   sec..year    : live calendar fields from main_control
//   send_req     : single-cycle request for a packet
//   txd          : serial line, idle high
//   busy         : packet in progress (START/DATA/STOP)
//   frame_done   : one-cycle pulse after the last stop bit
module dhtk_time_tx
   import dhtk_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 4,
   parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_p,
   input  logic [SEC_W-1:0]   sec,
   input  logic [MIN_W-1:0]   min,
   input  logic [HOUR_W-1:0]  hour,
   input  logic [DAY_W-1:0]   day,
   input  logic [MONTH_W-1:0] month,
   input  logic [YEAR_W-1:0]  year,
   input  logic               send_req,
   output logic               txd,
   output logic               busy,
   output logic               frame_done
);

   tx_state_t state_q, state_d;

   logic [SEC_W-1:0]   prev_sec;
   logic               pending;
   logic               trigger;
   logic [2:0]         byte_idx;
   logic [2:0]         byte_sel;
   logic [7:0]         byte_mux;
   logic               load;
   logic               start_end, data_end, byte_done;

   logic [SEC_W-1:0]   snap_sec;
   logic [MIN_W-1:0]   snap_min;
   logic [HOUR_W-1:0]  snap_hour;
   logic [DAY_W-1:0]   snap_day;
   logic [MONTH_W-1:0] snap_month;
   logic [YEAR_W-1:0]  snap_year;

   assign trigger = (sec != prev_sec) | send_req;

   always_ff @(posedge clk) begin
      if (rst_p) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      byte_sel   = byte_idx + 3'd1;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            busy     = 1'b0;
            byte_sel = 3'd0;
            if (trigger || pending) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: if (start_end) state_d = DATA;
         DATA:  if (data_end)  state_d = STOP;
         STOP: begin
            if (byte_done) begin
               if (byte_idx == 3'(NUM_BYTES - 1)) begin
                  state_d = DONE;
               end else begin
                  load    = 1'b1;
                  state_d = START;
               end
            end
         end
         DONE: begin
            busy       = 1'b0;
            frame_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DHTK_TX_CHECKSUM_EN
   logic [7:0] csum;
   assign csum = {2'b0, snap_sec} ^ {2'b0, snap_min} ^ {3'b0, snap_hour} ^
                 {3'b0, snap_day} ^ {snap_month, snap_year[11:8]} ^ snap_year[7:0];
`endif

   // SYNC (index 0) is only loaded from IDLE, before the snapshot registers
   // update, so it must not depend on them.
   always_comb begin
      byte_mux = 8'h00;
      case (byte_sel)
         3'd0: byte_mux = SYNC_BYTE;
         3'd1: byte_mux = {2'b0, snap_sec};
         3'd2: byte_mux = {2'b0, snap_min};
         3'd3: byte_mux = {3'b0, snap_hour};
         3'd4: byte_mux = {3'b0, snap_day};
         3'd5: byte_mux = {snap_month, snap_year[11:8]};
         3'd6: byte_mux = snap_year[7:0];
`ifdef DHTK_TX_CHECKSUM_EN
         3'd7: byte_mux = csum;
`endif
         default: byte_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         prev_sec   <= '0;
         pending    <= 1'b0;
         byte_idx   <= '0;
         snap_sec   <= '0;
         snap_min   <= '0;
         snap_hour  <= '0;
         snap_day   <= '0;
         snap_month <= '0;
         snap_year  <= '0;
      end else begin
         prev_sec <= sec;
         // In IDLE a pending request is always consumed on this edge, together
         // with any coincident trigger; outside IDLE triggers coalesce.
         if (state_q == IDLE)
            pending <= 1'b0;
         else if (trigger)
            pending <= 1'b1;
         if (load)
            byte_idx <= byte_sel;
         if (state_q == IDLE && load) begin
            snap_sec   <= sec;
            snap_min   <= min;
            snap_hour  <= hour;
            snap_day   <= day;
            snap_month <= month;
            snap_year  <= year;
         end
      end
   end

   dhtk_uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
      .clk       (clk),
      .rst_p     (rst_p),
      .load      (load),
      .byte_in   (byte_mux),
      .txd       (txd),
      .start_end (start_end),
      .data_end  (data_end),
      .byte_done (byte_done)
   );

endmodule

// File: tb/tb_dhtk_time_tx.sv
// tb_dhtk_time_tx: directed self-checking bench for dhtk_time_tx.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_dhtk_time_tx;

   localparam int CPB = 4;
`ifdef DHTK_TX_CHECKSUM_EN
   localparam int NB = 8;
`else
   localparam int NB = 7;
`endif
   localparam int K = NB * 10 * CPB;   // edges from snapshot to the DONE cycle

   logic        clk = 1'b0;
   logic        rst_p;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic [4:0]  hour;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [11:0] year;
   logic        send_req;
   logic        txd, busy, frame_done;

   int total = 0;
   int bad   = 0;

   logic       cap_txd [0:1023];
   logic       cap_bz  [0:1023];
   logic       cap_fd  [0:1023];
   logic [5:0] cap_sec [0:1023];

   always #5 clk = ~clk;

   dhtk_time_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .clk        (clk),
      .rst_p      (rst_p),
      .sec        (sec),
      .min        (min),
      .hour       (hour),
      .day        (day),
      .month      (month),
      .year       (year),
      .send_req   (send_req),
      .txd        (txd),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // index 0 holds the values visible right now; each later index is one edge on
   task automatic grab(input int n, input bit inc);
      for (int i = 0; i < n; i++) begin
         cap_txd[i] = txd;
         cap_bz[i]  = busy;
         cap_fd[i]  = frame_done;
         if (inc) sec = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
         cap_sec[i] = sec;
         tick();
      end
   endtask

   // byte k of a packet whose start bit was first observed at index base
   function automatic logic [7:0] dec(input int base, input int k);
      logic [7:0] d;
      for (int b = 0; b < 8; b++)
         d[b] = cap_txd[base + (k * 10 + 1 + b) * CPB + CPB / 2];
      return d;
   endfunction

   function automatic int count_ones_fd(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (cap_fd[i]) c++;
      return c;
   endfunction

   task automatic wait_idle();
      int run = 0;
      int n   = 0;
      while (run < 20 && n < 5000) begin
         tick();
         n++;
         run = busy ? 0 : run + 1;
      end
      chk("drain_in_budget", 32'(n < 5000), 32'd1);
   endtask

   initial begin
      logic [7:0] exp_b [0:7];
      int j1, j2, c0, c1, c2;

      rst_p = 1'b1; send_req = 1'b0;
      sec = 6'd0; min = 6'd7; hour = 5'd13; day = 5'd4; month = 4'd9; year = 12'h7E8;
      repeat (3) tick();
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fd", frame_done, 0);
      rst_p = 1'b0;

      // quiet line while sec holds at its reset value
      grab(50, 0);
      c0 = 0; c1 = 0;
      for (int i = 0; i < 50; i++) begin
         if (!cap_txd[i]) c0++;
         if (cap_bz[i]) c1++;
      end
      chk("idle_txd_low_cycles", c0, 0);
      chk("idle_busy_cycles", c1, 0);
      chk("idle_fd_pulses", count_ones_fd(50), 0);

      // second change -> full packet
      sec = 6'd5;
      tick();
      min = 6'd33;   // after the snapshot: must not reach the line
      grab(K + 4, 0);
      exp_b[0] = 8'hA5; exp_b[1] = 8'h05; exp_b[2] = 8'h07; exp_b[3] = 8'h0D;
      exp_b[4] = 8'h04; exp_b[5] = 8'h97; exp_b[6] = 8'hE8;
      exp_b[7] = 8'h05 ^ 8'h07 ^ 8'h0D ^ 8'h04 ^ 8'h97 ^ 8'hE8;
      chk("pkt_start_txd", cap_txd[0], 0);
      chk("pkt_start_busy", cap_bz[0], 1);
      for (int k = 0; k < NB; k++)
         chk($sformatf("pkt_byte%0d", k), dec(0, k), exp_b[k]);
      chk("pkt_fd_at_K", cap_fd[K], 1);
      chk("pkt_fd_count", count_ones_fd(K + 4), 1);
      chk("pkt_busy_last_stop", cap_bz[K - 1], 1);
      chk("pkt_busy_done", cap_bz[K], 0);
      chk("pkt_txd_done", cap_txd[K], 1);
      chk("pkt_stop_bit_last", cap_txd[K - 1], 1);
      min = 6'd7;

      // send_req, then a second send_req mid-packet -> one extra packet
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      chk("req_start_txd", txd, 0);
      repeat (99) tick();
      send_req = 1'b1;
      tick();                    // edge 100
      send_req = 1'b0;
      hour = 5'd20;              // visible only to the follow-on packet
      repeat (K - 101) tick();   // edge K-1
      chk("req_fd_before", frame_done, 0);
      tick();                    // edge K
      chk("req_fd", frame_done, 1);
      chk("req_busy_done", busy, 0);
      tick();                    // edge K+1
      chk("req_gap_txd", txd, 1);
      chk("req_gap_busy", busy, 0);
      tick();                    // edge K+2
      chk("req2_start_txd", txd, 0);
      chk("req2_start_busy", busy, 1);
      grab(K + 30, 0);
      chk("req2_sec", dec(0, 1), 8'h05);
      chk("req2_hour", dec(0, 3), 8'h14);
      chk("req2_fd_count", count_ones_fd(K + 30), 1);
      chk("req2_idle_after", busy, 0);

      // free-running seconds: packets chained through pending
      grab(2 * K + 60, 1);
      j1 = -1; j2 = -1;
      for (int i = 0; i < 2 * K + 60; i++) if (j1 < 0 && cap_bz[i]) j1 = i;
      if (j1 >= 0)
         for (int i = j1 + K; i < 2 * K + 60; i++) if (j2 < 0 && cap_bz[i]) j2 = i;
      chk("run_first_start", j1, 1);
      chk("run_spacing", j2 - j1, K + 2);
      if (j1 >= 1 && j2 >= 1) begin
         chk("run_p1_sec", dec(j1, 1), {2'b0, cap_sec[j1 - 1]});
         chk("run_p2_sec", dec(j2, 1), {2'b0, cap_sec[j2 - 1]});
      end
      wait_idle();

      // reset in the middle of B2 data bit 3 with a request pending
      sec = 6'd0;
      tick();                    // snapshot edge 0
      repeat (49) tick();
      send_req = 1'b1;
      tick();                    // edge 50
      send_req = 1'b0;
      repeat (47) tick();        // edge 97: inside B2 bit 3
      chk("abort_b2_bit3", txd, (7 >> 3) & 1);
      chk("abort_busy_pre", busy, 1);
      rst_p = 1'b1;
      tick();
      chk("abort_txd", txd, 1);
      chk("abort_busy", busy, 0);
      chk("abort_fd", frame_done, 0);
      rst_p = 1'b0;
      grab(300, 0);
      c0 = 0; c2 = 0;
      for (int i = 0; i < 300; i++) begin
         if (!cap_txd[i]) c0++;
         if (cap_bz[i]) c2++;
      end
      chk("post_abort_txd_low", c0, 0);
      chk("post_abort_busy", c2, 0);
      chk("post_abort_fd", count_ones_fd(300), 0);
      send_req = 1'b1;
      tick();
      send_req = 1'b0;
      chk("post_abort_req_txd", txd, 0);
      chk("post_abort_req_busy", busy, 1);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
